// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, FSM states and digit legality helper for BCD conversion
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd2bin_step.sv
// rtl/bcd2bin_step.sv - one reverse double-dabble step: shift right, then fix BCD nibbles >= 8
module bcd2bin_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic [4*DIGITS+BIN_W-1:0] work_in,
    output logic [4*DIGITS+BIN_W-1:0] work_out
);

    bcd_digit_t nib;

    // Only the BCD field is corrected; the bin field just receives shifted-out bits.
    always_comb begin
        work_out = work_in >> 1;
        nib      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = work_out[BIN_W+4*i +: 4];
            if (nib >= 4'd8) begin
                work_out[BIN_W+4*i +: 4] = nib - 4'd3;
            end
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter with valid/ready handshakes
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  bcd_err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    generate
        if ((2 ** BIN_W) < (10 ** DIGITS)) begin : g_width_check
            $error("bcd2bin_seq: BIN_W too small to hold 10**DIGITS-1");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d, work_step;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [BIN_W-1:0]    bin_out_q, bin_out_d;
    logic                bcd_err_q, bcd_err_d;
    logic                err_in;

    bcd2bin_step #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_step (
        .work_in  (work_q),
        .work_out (work_step)
    );

    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            err_in = err_in | ~bcd_valid(bcd_in[4*i +: 4]);
        end
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        bin_out_d   = bin_out_q;
        bcd_err_d   = bcd_err_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    work_d     = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d      = '0;
                    err_d      = err_in;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                work_d = work_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_valid_d = 1'b1;
                    bin_out_d   = err_q ? '0 : work_step[BIN_W-1:0];
                    bcd_err_d   = err_q;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
            bcd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bin_out_q   <= bin_out_d;
            bcd_err_q   <= bcd_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed self-checking bench for bcd2bin_seq
module tb_bcd2bin_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  bin_out;
    logic        bcd_err;

    int checks   = 0;
    int failures = 0;

    bcd2bin_seq #(
        .DIGITS (3),
        .BIN_W  (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .bcd_err   (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic run_op(input string tag, input logic [11:0] bcd, input int exp_bin,
                          input logic exp_err);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        bcd_in   = bcd;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bcd_in   = 12'hFFF;
        chk({tag, "_busy_in_ready"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_bin"}, int'(bin_out), exp_bin);
        chk({tag, "_err"}, int'(bcd_err), int'(exp_err));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"}, int'(out_valid), 0);
    endtask

    initial begin
        int seen;
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_bcd_err", int'(bcd_err), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", int'(in_ready), 1);

        run_op("max999", 12'h999, 999, 1'b0);
        run_op("b2b_000", 12'h000, 0, 1'b0);
        run_op("b2b_255", 12'h255, 255, 1'b0);
        run_op("b2b_100", 12'h100, 100, 1'b0);
        run_op("illegal_1A3", 12'h1A3, 0, 1'b1);
        run_op("after_err_042", 12'h042, 42, 1'b0);

        // Backpressure: result held while out_ready is low, new requests ignored
        bcd_in   = 12'h123;
        in_valid = 1'b1;
        tick();
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("hold_latency", lat, 10);
        for (int i = 0; i < 5; i++) begin
            bcd_in = (i % 2 == 0) ? 12'h456 : 12'h987;
            tick();
            chk("hold_bin", int'(bin_out), 123);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        bcd_in    = 12'h456;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_valid", int'(out_valid), 0);
        chk("hold_release_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        bcd_in   = 12'h000;
        chk("hold_new_accept", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("hold_new_latency", lat, 10);
        chk("hold_new_bin", int'(bin_out), 456);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a conversion discards it
        bcd_in   = 12'h789;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_bin_out", int'(bin_out), 0);
        chk("midrst_bcd_err", int'(bcd_err), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);
        run_op("after_rst_321", 12'h321, 321, 1'b0);

        for (int d2 = 0; d2 < 10; d2++) begin
            for (int d1 = 0; d1 < 10; d1++) begin
                for (int d0 = 0; d0 < 10; d0++) begin
                    run_op("sweep", {4'(d2), 4'(d1), 4'(d0)}, 100 * d2 + 10 * d1 + d0, 1'b0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
